// File: rtl/regbank_sb_pkg.sv
// Shared constants for the regbank_sb register bank and its scoreboard.
package regbank_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_NREGS  = 32;
   localparam int unsigned ZERO_IDX   = 0;

endpackage

// File: rtl/regbank_sb_if.sv
// Decode/writeback <-> register bank bus: read ports, issue marking and writeback.
interface regbank_sb_if #(
   parameter int unsigned DATA_W = regbank_pkg::DEF_DATA_W,
   parameter int unsigned ADDR_W = $clog2(regbank_pkg::DEF_NREGS)
) ();

   logic              rd_en;
   logic [ADDR_W-1:0] rs;
   logic [ADDR_W-1:0] rt;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic              rd_valid;
   logic              hazard;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_rd;
   logic              wr_en;
   logic [ADDR_W-1:0] rd;
   logic [DATA_W-1:0] i_data;

   modport master (
      output rd_en, rs, rt, iss_en, iss_rd, wr_en, rd, i_data,
      input  a, b, rd_valid, hazard
   );

   modport slave (
      input  rd_en, rs, rt, iss_en, iss_rd, wr_en, rd, i_data,
      output a, b, rd_valid, hazard
   );

endinterface

// File: rtl/rb_scoreboard.sv
// Per-register pending scoreboard with issue/clear update and source-pending lookup.
// Forwarding from writeback is honoured when REGBANK_BYPASS_EN is defined.
module rb_scoreboard
   import regbank_pkg::*;
#(
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned ADDR_W   = $clog2(NREGS),
   parameter int unsigned ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_iss_en,
   input  logic [ADDR_W-1:0] i_iss_rd,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_rd,
   input  logic [ADDR_W-1:0] i_rs,
   input  logic [ADDR_W-1:0] i_rt,
   output logic              o_rs_pend_c,
   output logic              o_rt_pend_c
);

   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

   logic [NREGS-1:0] r_pending;
   logic [NREGS-1:0] w_pending_nxt;
   logic             w_iss_ok;
   logic             w_wr_ok;
   logic             w_byp_rs;
   logic             w_byp_rt;

   assign w_iss_ok = i_iss_en && !((ZERO_REG != 0) && (i_iss_rd == ZERO_A));
   assign w_wr_ok  = i_wr_en  && !((ZERO_REG != 0) && (i_wr_rd  == ZERO_A));

   // Clear first, then set: an issue in the same cycle as a writeback keeps the bit.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_wr_ok)  w_pending_nxt[i_wr_rd]  = 1'b0;
      if (w_iss_ok) w_pending_nxt[i_iss_rd] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pending <= '0;
      else        r_pending <= w_pending_nxt;
   end

`ifdef REGBANK_BYPASS_EN
   assign w_byp_rs = i_wr_en && (i_wr_rd == i_rs);
   assign w_byp_rt = i_wr_en && (i_wr_rd == i_rt);
`else
   assign w_byp_rs = 1'b0;
   assign w_byp_rt = 1'b0;
`endif

   assign o_rs_pend_c = r_pending[i_rs] && !w_byp_rs;
   assign o_rt_pend_c = r_pending[i_rt] && !w_byp_rt;

endmodule

// File: rtl/regbank_sb.sv
// DATA_W x NREGS register bank with two registered read ports, one write port,
// optional hardwired zero register and RAW scoreboard. Optional macro: REGBANK_BYPASS_EN.
module regbank_sb
   import regbank_pkg::*;
#(
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned NREGS    = DEF_NREGS,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regbank_sb_if.slave  bus
);

   localparam int unsigned       ADDR_W = $clog2(NREGS);
   localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

   logic [DATA_W-1:0] r_regs [NREGS];
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic              r_rd_valid;

   logic              w_rs_pend;
   logic              w_rt_pend;
   logic              w_hazard;
   logic              w_rd_acc;
   logic              w_wr_ok;
   logic [DATA_W-1:0] w_val_a;
   logic [DATA_W-1:0] w_val_b;

   rb_scoreboard #(
      .NREGS    (NREGS),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk         (clk),
      .rst_n       (rst),
      .i_iss_en    (bus.iss_en),
      .i_iss_rd    (bus.iss_rd),
      .i_wr_en     (bus.wr_en),
      .i_wr_rd     (bus.rd),
      .i_rs        (bus.rs),
      .i_rt        (bus.rt),
      .o_rs_pend_c (w_rs_pend),
      .o_rt_pend_c (w_rt_pend)
   );

   assign w_hazard = bus.rd_en && (w_rs_pend || w_rt_pend);
   assign w_rd_acc = bus.rd_en && !w_hazard;
   assign w_wr_ok  = bus.wr_en && !((ZERO_REG != 0) && (bus.rd == ZERO_A));

   // Source value: zero register beats forwarding beats array contents.
   always_comb begin
      w_val_a = r_regs[bus.rs];
      w_val_b = r_regs[bus.rt];
`ifdef REGBANK_BYPASS_EN
      if (bus.wr_en && (bus.rd == bus.rs)) w_val_a = bus.i_data;
      if (bus.wr_en && (bus.rd == bus.rt)) w_val_b = bus.i_data;
`endif
      if ((ZERO_REG != 0) && (bus.rs == ZERO_A)) w_val_a = '0;
      if ((ZERO_REG != 0) && (bus.rt == ZERO_A)) w_val_b = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      end else if (w_wr_ok) begin
         r_regs[bus.rd] <= bus.i_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a        <= '0;
         r_b        <= '0;
         r_rd_valid <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_a <= w_val_a;
            r_b <= w_val_b;
         end
      end
   end

   assign bus.a        = r_a;
   assign bus.b        = r_b;
   assign bus.rd_valid = r_rd_valid;
   assign bus.hazard   = w_hazard;

endmodule

// File: tb/tb_regbank_sb.sv
// Directed vector bench for regbank_sb (default 32x32, ZERO_REG=1); expectations
// follow REGBANK_BYPASS_EN when the bench is built with it.
module tb_regbank_sb;

   typedef struct {
      logic        rd_en;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        iss_en;
      logic [4:0]  iss_rd;
      logic        wr_en;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        exp_h;
      logic        exp_v;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
   } vec_t;

`ifdef REGBANK_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   localparam int NV = 22;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   vec_t vt [NV];

   regbank_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   regbank_sb #(.DATA_W(32), .NREGS(32), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic re, input logic [4:0] rs_i, input logic [4:0] rt_i,
                               input logic ie, input logic [4:0] ir,
                               input logic we, input logic [4:0] rd_i, input logic [31:0] d,
                               input logic eh, input logic ev,
                               input logic [31:0] ea, input logic [31:0] eb);
      vec_t v;
      v.rd_en = re; v.rs = rs_i; v.rt = rt_i;
      v.iss_en = ie; v.iss_rd = ir;
      v.wr_en = we; v.rd = rd_i; v.data = d;
      v.exp_h = eh; v.exp_v = ev; v.exp_a = ea; v.exp_b = eb;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic drive_idle();
      bus.rd_en = 1'b0; bus.rs = '0; bus.rt = '0;
      bus.iss_en = 1'b0; bus.iss_rd = '0;
      bus.wr_en = 1'b0; bus.rd = '0; bus.i_data = '0;
   endtask

   // One cycle: drive after negedge, check hazard before the edge, outputs after it.
   task automatic step(input vec_t v, input string nm);
      @(negedge clk);
      bus.rd_en = v.rd_en; bus.rs = v.rs; bus.rt = v.rt;
      bus.iss_en = v.iss_en; bus.iss_rd = v.iss_rd;
      bus.wr_en = v.wr_en; bus.rd = v.rd; bus.i_data = v.data;
      #1;
      chk({nm, " hazard"}, 32'(bus.hazard), 32'(v.exp_h));
      @(posedge clk);
      #1;
      chk({nm, " rd_valid"}, 32'(bus.rd_valid), 32'(v.exp_v));
      chk({nm, " a"}, bus.a, v.exp_a);
      chk({nm, " b"}, bus.b, v.exp_b);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;

      //        rd rs  rt  is ir  wr rd  data           h  v  a              b
      vt[0]  = mk(1, 3,  7,  0, 0,  0, 0,  32'h0,         0, 1, 32'h0,         32'h0);
      vt[1]  = mk(0, 0,  0,  0, 0,  1, 5,  32'hDEADBEEF,  0, 0, 32'h0,         32'h0);
      vt[2]  = mk(1, 5,  3,  0, 0,  0, 0,  32'h0,         0, 1, 32'hDEADBEEF,  32'h0);
      vt[3]  = mk(1, 0,  5,  0, 0,  1, 0,  32'h1234,      0, 1, 32'h0,         32'hDEADBEEF);
      vt[4]  = mk(1, 0,  0,  0, 0,  0, 0,  32'h0,         0, 1, 32'h0,         32'h0);
      vt[5]  = mk(1, 5,  5,  1, 0,  0, 0,  32'h0,         0, 1, 32'hDEADBEEF,  32'hDEADBEEF);
      vt[6]  = mk(1, 0,  0,  0, 0,  0, 0,  32'h0,         0, 1, 32'h0,         32'h0);
      vt[7]  = mk(1, 12, 5,  0, 0,  1, 12, 32'hCAFE0001,  0, 1,
                  BYP ? 32'hCAFE0001 : 32'h0, 32'hDEADBEEF);
      vt[8]  = mk(1, 12, 12, 0, 0,  0, 0,  32'h0,         0, 1, 32'hCAFE0001,  32'hCAFE0001);
      vt[9]  = mk(0, 0,  0,  1, 9,  0, 0,  32'h0,         0, 0, 32'hCAFE0001,  32'hCAFE0001);
      vt[10] = mk(1, 9,  5,  0, 0,  0, 0,  32'h0,         1, 0, 32'hCAFE0001,  32'hCAFE0001);
      vt[11] = mk(1, 5,  9,  0, 0,  0, 0,  32'h0,         1, 0, 32'hCAFE0001,  32'hCAFE0001);
      vt[12] = BYP ? mk(1, 9, 5, 0, 0, 1, 9, 32'h55, 0, 1, 32'h55, 32'hDEADBEEF)
                   : mk(1, 9, 5, 0, 0, 1, 9, 32'h55, 1, 0, 32'hCAFE0001, 32'hCAFE0001);
      vt[13] = mk(1, 9,  12, 0, 0,  0, 0,  32'h0,         0, 1, 32'h55,        32'hCAFE0001);
      vt[14] = mk(0, 0,  0,  1, 4,  1, 4,  32'h77,        0, 0, 32'h55,        32'hCAFE0001);
      vt[15] = mk(1, 4,  0,  0, 0,  0, 0,  32'h0,         1, 0, 32'h55,        32'hCAFE0001);
      vt[16] = mk(1, 5,  5,  0, 0,  1, 4,  32'h88,        0, 1, 32'hDEADBEEF,  32'hDEADBEEF);
      vt[17] = mk(1, 4,  9,  0, 0,  0, 0,  32'h0,         0, 1, 32'h88,        32'h55);
      vt[18] = mk(1, 20, 20, 1, 20, 0, 0,  32'h0,         0, 1, 32'h0,         32'h0);
      vt[19] = mk(1, 20, 3,  0, 0,  0, 0,  32'h0,         1, 0, 32'h0,         32'h0);
      vt[20] = mk(0, 0,  0,  0, 0,  1, 31, 32'hFFFFFFFF,  0, 0, 32'h0,         32'h0);
      vt[21] = mk(1, 31, 31, 0, 0,  0, 0,  32'h0,         0, 1, 32'hFFFFFFFF,  32'hFFFFFFFF);

      drive_idle();
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset a", bus.a, 32'h0);
      chk("reset b", bus.b, 32'h0);
      chk("reset rd_valid", 32'(bus.rd_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) step(vt[i], $sformatf("vec%0d", i));

      // Async reset between edges, with pending[2] set and reg 2 holding 0xA.
      step(mk(0, 0, 0, 0, 0, 1, 2, 32'hA, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF), "arst_wr");
      step(mk(1, 2, 31, 1, 2, 0, 0, 32'h0, 0, 1, 32'hA, 32'hFFFFFFFF), "arst_iss");
      #2;
      rst = 1'b0;
      #1;
      chk("arst a", bus.a, 32'h0);
      chk("arst b", bus.b, 32'h0);
      chk("arst rd_valid", 32'(bus.rd_valid), 32'h0);
      drive_idle();
      @(negedge clk);
      rst = 1'b1;
      step(mk(1, 2, 2, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0), "post_arst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
